// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the core memory bus arbiter: FSM states, master IDs
// and the one-hot owner decode used for routing responses and grants.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    localparam logic [1:0] M_JTAG     = 2'd0;
    localparam logic [1:0] M_LSU      = 2'd1;
    localparam logic [1:0] M_IFU      = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    function automatic logic [2:0] owner_onehot(input logic [1:0] id);
        logic [2:0] oh;
        oh = 3'b000;
        case (id)
            M_JTAG:  oh = 3'b001;
            M_LSU:   oh = 3'b010;
            M_IFU:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio_enc.sv
// Fixed-priority encoder for three requesters: bit 0 wins, then bit 1, then bit 2.
// Purely combinational; id is OWNER_NONE when nothing requests.
module arb_prio_enc3
    import mem_bus_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    output logic [1:0] id_o,
    output logic       vld_o
);

    always_comb begin
        id_o = OWNER_NONE;
        if (req_i[0]) begin
            id_o = M_JTAG;
        end else if (req_i[1]) begin
            id_o = M_LSU;
        end else if (req_i[2]) begin
            id_o = M_IFU;
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares the core memory bus between JTAG (m0), LSU (m1) and IFU (m2), one transaction per grant.
// Latency: 3 cycles min request->response, one IDLE bubble between transactions; optional BUS_TIMEOUT_EN.
// Backpressure: s_gnt_i holds the owner in REQ, s_rvalid_i in WAIT; bus_wait_o/access_mem_hold_o stall the pipe.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    input  logic              m2_req_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    input  logic [DATA_W-1:0] m2_wdata_i,
    output logic              m2_gnt_o,
    output logic              m2_rvalid_o,
    output logic [DATA_W-1:0] m2_rdata_o,
    output logic              m2_err_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic              bus_wait_o,
    output logic              access_mem_hold_o
);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [2:0]        req_vec;
    logic [1:0]        enc_id;
    logic              enc_vld;
    logic [2:0]        owner_oh;
    logic              owner_req;
    logic [2:0]        gnt_vec;
    logic [2:0]        rvalid_vec;
    logic [2:0]        err_vec;
    logic              rsp_vld;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              to_hit;

    assign req_vec   = {m2_req_i, m1_req_i, m0_req_i};
    assign owner_oh  = owner_onehot(owner_q);
    assign owner_req = |(req_vec & owner_oh);

    arb_prio_enc3 u_prio_enc (
        .req_i (req_vec),
        .id_o  (enc_id),
        .vld_o (enc_vld)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Zero whenever idle, so the first REQ cycle always sees a count of 0.
    always_comb begin
        cnt_d = '0;
        if (state_q != ST_IDLE && state_d != ST_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign to_hit = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TO_CYCLES));
`else
    logic unused_cfg;
    assign unused_cfg = (TO_CYCLES == 0);
    assign to_hit     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        s_req_o = 1'b0;
        gnt_vec = 3'b000;
        rsp_vld = 1'b0;
        rsp_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    owner_d = enc_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (to_hit) begin
                    rsp_vld = 1'b1;
                    rsp_err = 1'b1;
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end else begin
                    s_req_o = 1'b1;
                    if (s_gnt_i) begin
                        gnt_vec = owner_oh;
                        state_d = ST_WAIT;
                    end else if (!owner_req) begin
                        // Owner withdrew before the slave accepted: nothing was issued.
                        state_d = ST_IDLE;
                        owner_d = OWNER_NONE;
                    end
                end
            end
            ST_WAIT: begin
                if (to_hit) begin
                    rsp_vld = 1'b1;
                    rsp_err = 1'b1;
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end else if (s_rvalid_i) begin
                    rsp_vld = 1'b1;
                    state_d = ST_IDLE;
                    owner_d = OWNER_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWNER_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        case (owner_q)
            M_JTAG: begin
                s_we_o    = m0_we_i;
                s_addr_o  = m0_addr_i;
                s_wdata_o = m0_wdata_i;
            end
            M_LSU: begin
                s_we_o    = m1_we_i;
                s_addr_o  = m1_addr_i;
                s_wdata_o = m1_wdata_i;
            end
            M_IFU: begin
                s_we_o    = m2_we_i;
                s_addr_o  = m2_addr_i;
                s_wdata_o = m2_wdata_i;
            end
            default: ;
        endcase
    end

    assign rvalid_vec = owner_oh & {3{rsp_vld}};
    assign err_vec    = owner_oh & {3{rsp_err}};
    assign rsp_data   = rsp_err ? '0 : s_rdata_i;

    assign m0_gnt_o    = gnt_vec[0];
    assign m1_gnt_o    = gnt_vec[1];
    assign m2_gnt_o    = gnt_vec[2];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m2_rvalid_o = rvalid_vec[2];
    assign m0_err_o    = err_vec[0];
    assign m1_err_o    = err_vec[1];
    assign m2_err_o    = err_vec[2];
    assign m0_rdata_o  = rvalid_vec[0] ? rsp_data : '0;
    assign m1_rdata_o  = rvalid_vec[1] ? rsp_data : '0;
    assign m2_rdata_o  = rvalid_vec[2] ? rsp_data : '0;

    assign bus_wait_o = m2_req_i &
                        ~((owner_q == M_IFU) && (state_q == ST_WAIT) && s_rvalid_i);
    assign access_mem_hold_o = (m1_req_i | ((owner_q == M_LSU) && (state_q != ST_IDLE)))
                               & ~rvalid_vec[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized masters/slave
// checked every cycle against a transaction-level model of the bus ownership rules.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    req = '0;
    logic [2:0]    we  = '0;
    logic [AW-1:0] addr  [3];
    logic [DW-1:0] wdata [3];
    logic          s_gnt = 1'b0;
    logic          s_rvalid = 1'b0;
    logic [DW-1:0] s_rdata = '0;

    logic          m0_gnt, m1_gnt, m2_gnt, m0_rv, m1_rv, m2_rv, m0_err, m1_err, m2_err;
    logic [DW-1:0] m0_rdata, m1_rdata, m2_rdata;
    logic          s_req_o, s_we_o, bus_wait_o, hold_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .m2_req_i(req[2]), .m2_we_i(we[2]), .m2_addr_i(addr[2]), .m2_wdata_i(wdata[2]),
        .m2_gnt_o(m2_gnt), .m2_rvalid_o(m2_rv), .m2_rdata_o(m2_rdata), .m2_err_o(m2_err),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .bus_wait_o(bus_wait_o), .access_mem_hold_o(hold_o)
    );

    logic [2:0] gnt_v, rv_v, err_v;
    assign gnt_v = {m2_gnt, m1_gnt, m0_gnt};
    assign rv_v  = {m2_rv, m1_rv, m0_rv};
    assign err_v = {m2_err, m1_err, m0_err};

    int checks = 0;
    int errors = 0;

    // Model: bus either free (arbitration this cycle) or owned by mdl_own,
    // which is either still waiting for acceptance or waiting for its response.
    bit       mdl_free = 1'b1;
    bit       mdl_granted = 1'b0;
    int       mdl_own = 0;
    int       mdl_age = 0;
    bit [2:0] pend = '0;
    int       gnt_ord = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [2:0]    e_gnt, e_rv, e_err;
        logic [DW-1:0] e_rd;
        bit            e_sreq, busy, to_now, e_wait, e_hold;
        int            own;
        #1;
        e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_sreq = 1'b0; to_now = 1'b0;
        busy = !mdl_free;
        own  = mdl_own;
        e_wait = req[2] && !(busy && mdl_granted && own == 2 && s_rvalid);
        if (!busy) begin
            if (req != 3'b000) begin
                mdl_own = req[0] ? 0 : (req[1] ? 1 : 2);
                mdl_free = 1'b0;
                mdl_granted = 1'b0;
                mdl_age = 0;
            end
        end else begin
`ifdef BUS_TIMEOUT_EN
            if (mdl_age == TB_TO) begin
                e_rv[own] = 1'b1;
                e_err[own] = 1'b1;
                mdl_free = 1'b1;
                to_now = 1'b1;
            end
`endif
            if (!to_now) begin
                if (!mdl_granted) begin
                    e_sreq = 1'b1;
                    if (s_gnt) begin
                        e_gnt[own] = 1'b1;
                        mdl_granted = 1'b1;
                    end else if (!req[own]) begin
                        mdl_free = 1'b1;
                    end
                end else if (s_rvalid) begin
                    e_rv[own] = 1'b1;
                    e_rd = s_rdata;
                    mdl_free = 1'b1;
                end
                mdl_age++;
            end
        end
        e_hold = (req[1] || (busy && own == 1)) && !e_rv[1];

        check_eq("s_req", s_req_o, e_sreq);
        if (e_sreq) begin
            check_eq("s_addr", s_addr_o, addr[own]);
            check_eq("s_we", s_we_o, we[own]);
            check_eq("s_wdata", s_wdata_o, wdata[own]);
        end
        check_eq("gnt", gnt_v, e_gnt);
        check_eq("rvalid", rv_v, e_rv);
        check_eq("err", err_v, e_err);
        check_eq("rdata0", m0_rdata, e_rv[0] ? e_rd : '0);
        check_eq("rdata1", m1_rdata, e_rv[1] ? e_rd : '0);
        check_eq("rdata2", m2_rdata, e_rv[2] ? e_rd : '0);
        check_eq("bus_wait", bus_wait_o, e_wait);
        check_eq("mem_hold", hold_o, e_hold);
        for (int i = 0; i < 3; i++) begin
            if (gnt_v[i]) gnt_ord = gnt_ord * 4 + i + 1;
            if (e_gnt[i]) pend[i] = 1'b0;
        end
    endtask

    task automatic drv(input logic [2:0] r, input logic g, input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        req = r; s_gnt = g; s_rvalid = v; s_rdata = d;
        cycle();
    endtask

    task automatic drive_random();
        for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
                pend[i]  = 1'b1;
                we[i]    = 1'($urandom_range(1));
                addr[i]  = $urandom;
                wdata[i] = $urandom;
            end
            req[i] = pend[i];
        end
        s_gnt    = (!mdl_free && !mdl_granted) ? 1'($urandom_range(1)) : 1'b0;
        s_rvalid = (!mdl_free && mdl_granted) ? ($urandom_range(4) < 2) : ($urandom_range(7) == 0);
        s_rdata  = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end
        @(negedge clk);
        cycle();
        check_eq("rst_s_req", s_req_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // m2 read of 0x100 with immediate accept and response.
        we[2] = 1'b0; addr[2] = 32'h100; wdata[2] = '0;
        drv(3'b100, 1'b0, 1'b0, '0);
        drv(3'b100, 1'b1, 1'b0, '0);
        check_eq("t1_gnt", m2_gnt, 1'b1);
        drv(3'b100, 1'b0, 1'b1, 32'hDEADBEEF);
        check_eq("t1_rvalid", m2_rv, 1'b1);
        check_eq("t1_rdata", m2_rdata, 32'hDEADBEEF);
        check_eq("t1_bus_wait", bus_wait_o, 1'b0);
        drv(3'b000, 1'b0, 1'b0, '0);

        // All three request together: served m0, m1, m2.
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0; addr[i] = 32'h40 * (i + 1); wdata[i] = 32'h11 * (i + 1);
        end
        gnt_ord = 0;
        drv(3'b111, 1'b0, 1'b0, '0);
        drv(3'b111, 1'b1, 1'b0, '0);
        drv(3'b110, 1'b0, 1'b1, 32'h0A);
        check_eq("t2_hold_m0_rsp", hold_o, 1'b1);
        drv(3'b110, 1'b0, 1'b0, '0);
        drv(3'b110, 1'b1, 1'b0, '0);
        drv(3'b100, 1'b0, 1'b1, 32'h0B);
        check_eq("t2_hold_m1_rsp", hold_o, 1'b0);
        drv(3'b100, 1'b0, 1'b0, '0);
        drv(3'b100, 1'b1, 1'b0, '0);
        drv(3'b000, 1'b0, 1'b1, 32'h0C);
        check_eq("t2_order", gnt_ord, 27);

        // m1 write with a slow slave accept.
        we[1] = 1'b1; addr[1] = 32'h2000; wdata[1] = 32'h55AA;
        gnt_ord = 0;
        drv(3'b010, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            drv(3'b010, 1'b0, 1'b0, '0);
            check_eq("t3_s_req", s_req_o, 1'b1);
            check_eq("t3_addr", s_addr_o, 32'h2000);
            check_eq("t3_wdata", s_wdata_o, 32'h55AA);
        end
        drv(3'b010, 1'b1, 1'b0, '0);
        drv(3'b000, 1'b0, 1'b1, 32'h1);
        check_eq("t3_one_gnt", gnt_ord, 2);

        // m0 arrives while m2 waits for its response: no preemption.
        gnt_ord = 0;
        drv(3'b100, 1'b0, 1'b0, '0);
        drv(3'b100, 1'b1, 1'b0, '0);
        drv(3'b001, 1'b0, 1'b0, '0);
        drv(3'b001, 1'b0, 1'b1, 32'h77);
        check_eq("t4_m2_rv", m2_rv, 1'b1);
        drv(3'b001, 1'b0, 1'b0, '0);
        drv(3'b001, 1'b1, 1'b0, '0);
        drv(3'b000, 1'b0, 1'b1, 32'h88);
        check_eq("t4_order", gnt_ord, 13);

        // m1 withdraws before acceptance.
        gnt_ord = 0;
        drv(3'b010, 1'b0, 1'b0, '0);
        drv(3'b000, 1'b0, 1'b0, '0);
        drv(3'b000, 1'b0, 1'b0, '0);
        check_eq("t5_no_gnt", gnt_ord, 0);

        // Reset while m0 waits; a late response must be dropped.
        drv(3'b001, 1'b0, 1'b0, '0);
        drv(3'b001, 1'b1, 1'b0, '0);
        @(negedge clk);
        req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE;
        rst_n = 1'b0;
        #1;
        check_eq("rst_s_req_mid", s_req_o, 1'b0);
        check_eq("rst_rvalid_mid", rv_v, 3'b000);
        check_eq("rst_rdata0_mid", m0_rdata, '0);
        check_eq("rst_hold_mid", hold_o, 1'b0);
        mdl_free = 1'b1; pend = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_eq("rst_late_rv", rv_v, 3'b000);

`ifdef BUS_TIMEOUT_EN
        // Slave never accepts: timeout response with error after TB_TO cycles.
        drv(3'b010, 1'b0, 1'b0, 32'hFFFFFFFF);
        for (int k = 0; k <= TB_TO; k++) begin
            drv(3'b010, 1'b0, 1'b0, 32'hFFFFFFFF);
            check_eq("to_rvalid", m1_rv, k == TB_TO);
            check_eq("to_err", m1_err, k == TB_TO);
        end
        check_eq("to_rdata", m1_rdata, '0);
        drv(3'b000, 1'b0, 1'b0, '0);
        check_eq("to_idle_s_req", s_req_o, 1'b0);
`endif

        pend = '0;
        repeat (3000) begin
            @(negedge clk);
            drive_random();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus between three masters: JTAG debug (m0), load/store unit (m1) and instruction fetch (m2).
- Uses fixed priority and a registered owner. Each grant carries exactly one transaction: request, slave accept, then response.
- Generates the stall inputs consumed by pipeline flow control:
  - bus_wait_o for fetch starvation.
  - access_mem_hold_o for a pending data access.
- Sits between the core masters and the bus slave port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TO_CYCLES, 255, timeout limit in cycles; only used with the optional feature; counter width is clog2(TO_CYCLES+1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mN_req_i  in  1  request from master N, N=0..2; held stable until mN_gnt_o.
- mN_we_i  in  1  write enable, master N.
- mN_addr_i  in  ADDR_W  address, master N.
- mN_wdata_i  in  DATA_W  write data, master N.
- mN_gnt_o  out  1  one-cycle pulse: slave accepted master N's request.
- mN_rvalid_o  out  1  one-cycle pulse: response for master N.
- mN_rdata_o  out  DATA_W  read data, master N; zero unless mN_rvalid_o.
- mN_err_o  out  1  error flag qualified by mN_rvalid_o.
- s_req_o  out  1  request to slave.
- s_we_o  out  1  write enable to slave.
- s_addr_o  out  ADDR_W  address to slave.
- s_wdata_o  out  DATA_W  write data to slave.
- s_gnt_i  in  1  slave accepts the request this cycle.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DATA_W  slave read data.
- bus_wait_o  out  1  m2_req_i high and m2 not served this cycle.
- access_mem_hold_o  out  1  m1_req_i high, or m1 owns the bus and its response is not yet returned.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, owner=none, s_req_o=0, all mN_gnt_o/mN_rvalid_o/mN_err_o=0, all rdata outputs 0, timeout counter 0.
  - A reset mid-transaction abandons the transaction. A late s_rvalid_i after reset is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If any mN_req_i is high, latch owner = highest-priority requester (m0>m1>m2) and go to REQ.
  - The owner register is 2 bits; the "none" encoding is 3.
- REQ:
  - s_req_o=1. s_we/s_addr/s_wdata are routed combinationally from the owner's inputs.
  - On s_gnt_i: pulse owner gnt and go to WAIT.
  - If the owner's req_i drops while s_gnt_i=0: go to IDLE, no gnt.
  - Higher-priority requests arriving in REQ do not preempt.
- WAIT:
  - s_req_o=0.
  - On s_rvalid_i: owner rvalid_o=1 and owner rdata_o=s_rdata_i in the same cycle (combinational); go to IDLE.
  - s_gnt_i and s_rvalid_i in the same cycle as REQ→WAIT are not merged. The response is only taken in WAIT.
- Latency:
  - Minimum 3 cycles from request to response: cycle0 IDLE latch, cycle1 REQ+gnt, cycle2 WAIT+rvalid.
  - One IDLE bubble between back-to-back transactions.
- Stall outputs are combinational:
  - bus_wait_o = m2_req_i & !(owner==2 & state==WAIT & s_rvalid_i).
  - access_mem_hold_o = m1_req_i | (owner==1 & state!=IDLE), deasserted in the cycle m1_rvalid_o pulses.
- Starvation: fixed priority allows m0 to starve m1/m2. This is intended; JTAG halts the core anyway.
- Unused master outputs remain 0 at all times.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it equals TO_CYCLES, the owner gets rvalid_o=1, err_o=1 and rdata_o=0, and the block returns to IDLE.
  - s_req_o drops.
- Without the macro:
  - No counter; mN_err_o is tied to 0.
  - The block waits in REQ/WAIT indefinitely.

Decomposition:
- Shared defines header, next to the core defines:
  - State encodings (IDLE/REQ/WAIT).
  - Master IDs M_JTAG=0, M_LSU=1, M_IFU=2.
  - OWNER_NONE=3.
- One sub-module: arb_prio_enc3. It is a combinational fixed-priority encoder: 3 req bits in, 2-bit id and any-valid out.

Test Plan:
- m2 read 0x100, slave gnt in REQ, rdata 0xDEADBEEF one cycle later → m2_gnt pulse cycle1, m2_rvalid/rdata=0xDEADBEEF cycle2, bus_wait_o low cycle2.
- m0, m1 and m2 all request in the same cycle → served order m0, m1, m2, each separated by one IDLE cycle; access_mem_hold_o high until m1_rvalid.
- m1 write 0x2000/0x55AA, s_gnt_i delayed 4 cycles → s_req_o held 4 cycles with stable address/data; exactly one m1_gnt pulse.
- m2 owns the bus in WAIT, m0 requests → no preemption; m0 is served after m2_rvalid.
- rst_n pulsed low while in WAIT → all outputs 0 immediately; a following s_rvalid_i produces no mN_rvalid_o.
- BUS_TIMEOUT_EN, TO_CYCLES=8, slave never responds → owner rvalid=1, err=1, rdata=0 after 8 cycles; block returns to IDLE.
